// File: rtl/lif_sched_pkg.sv
// Shared types for the LIF tick scheduler: sweep FSM states and the spike-event record.
// The scheduler packs events into its FIFO in the same {id, ts} field order as evt_rec_t.
package lif_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    localparam int unsigned EVT_ID_W = 16;
    localparam int unsigned EVT_TS_W = 32;

    typedef struct packed {
        logic [EVT_ID_W-1:0] id;
        logic [EVT_TS_W-1:0] ts;
    } evt_rec_t;

endpackage

// File: rtl/lif_evt_fifo.sv
// Synchronous spike-event FIFO; a push and a pop in the same cycle both succeed even when full.
module lif_evt_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/lif_tick_scheduler.sv
// Timestep sweep scheduler for a shared LIF datapath, with spike-event FIFO and sticky status.
// LIF_SCHED_BACKPRESSURE_EN: when defined, requests stall while the event FIFO is full.
module lif_tick_scheduler
    import lif_sched_pkg::*;
#(
    parameter int unsigned  NUM_NEURONS = 64,
    parameter int unsigned  EVT_DEPTH   = 16,
    parameter int unsigned  TS_WIDTH    = 32,
    localparam int unsigned IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_start,
    output logic                busy,
    output logic                tick_done,
    output logic [TS_WIDTH-1:0] timestep,
    output logic                dp_req,
    output logic [IDX_W-1:0]    dp_idx,
    input  logic                dp_ack,
    input  logic                dp_spike,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [IDX_W-1:0]    evt_id,
    output logic [TS_WIDTH-1:0] evt_time,
    output logic                evt_overflow,
    output logic                tick_overrun,
    input  logic                clear_status
);

    localparam int unsigned      EVT_W    = IDX_W + TS_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    sched_state_t              state;
    logic                      xfer;
    logic                      evt_push;
    logic                      evt_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(EVT_DEPTH):0] fifo_count;
    logic [EVT_W-1:0]          fifo_head;

`ifdef LIF_SCHED_BACKPRESSURE_EN
    assign dp_req = (state == ISSUE) && !fifo_full;
`else
    assign dp_req = (state == ISSUE);
`endif

    assign xfer      = dp_req && dp_ack;
    assign evt_push  = xfer && dp_spike;
    assign evt_valid = (fifo_count != '0);
    assign evt_pop   = evt_valid && evt_ready;
    // Head is masked so stale storage never shows on the event outputs.
    assign {evt_id, evt_time} = fifo_empty ? '0 : fifo_head;

    lif_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (EVT_DEPTH)
    ) u_evt_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (evt_push),
        .push_data ({dp_idx, timestep}),
        .pop       (evt_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dp_idx    <= '0;
            timestep  <= '0;
            busy      <= 1'b0;
            tick_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick_start) begin
                        state  <= ISSUE;
                        dp_idx <= '0;
                        busy   <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (xfer) begin
                        if (dp_idx == LAST_IDX) begin
                            state     <= DONE;
                            tick_done <= 1'b1;
                            dp_idx    <= '0;
                        end else begin
                            dp_idx <= dp_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    tick_done <= 1'b0;
                    busy      <= 1'b0;
                    timestep  <= timestep + 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    tick_done <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flags: a coincident set beats clear_status.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_overrun <= 1'b0;
            evt_overflow <= 1'b0;
        end else begin
            if (tick_start && busy) begin
                tick_overrun <= 1'b1;
            end else if (clear_status) begin
                tick_overrun <= 1'b0;
            end
            if (evt_push && fifo_full && !evt_pop) begin
                evt_overflow <= 1'b1;
            end else if (clear_status) begin
                evt_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lif_tick_scheduler.sv
// Scoreboard bench for lif_tick_scheduler (NUM_NEURONS=4, EVT_DEPTH=2, TS_WIDTH=3).
module tb_lif_tick_scheduler;
    import lif_sched_pkg::*;

    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned TSW   = 3;
    localparam int unsigned IW    = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           tick_start;
    logic           busy;
    logic           tick_done;
    logic [TSW-1:0] timestep;
    logic           dp_req;
    logic [IW-1:0]  dp_idx;
    logic           dp_ack;
    logic           dp_spike;
    logic           evt_valid;
    logic           evt_ready;
    logic [IW-1:0]  evt_id;
    logic [TSW-1:0] evt_time;
    logic           evt_overflow;
    logic           tick_overrun;
    logic           clear_status;

    lif_tick_scheduler #(
        .NUM_NEURONS (N),
        .EVT_DEPTH   (DEPTH),
        .TS_WIDTH    (TSW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_start   (tick_start),
        .busy         (busy),
        .tick_done    (tick_done),
        .timestep     (timestep),
        .dp_req       (dp_req),
        .dp_idx       (dp_idx),
        .dp_ack       (dp_ack),
        .dp_spike     (dp_spike),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_id       (evt_id),
        .evt_time     (evt_time),
        .evt_overflow (evt_overflow),
        .tick_overrun (tick_overrun),
        .clear_status (clear_status)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    evt_rec_t       sb[$];
    int unsigned    ack_delay   = 0;
    int unsigned    wait_cnt    = 0;
    logic [N-1:0]   spike_mask  = '0;
    logic [IW-1:0]  exp_idx     = '0;
    logic [TSW-1:0] exp_ts      = '0;
    logic           exp_ovf     = 1'b0;
    int unsigned    xfers       = 0;
    int unsigned    done_cnt    = 0;
    int unsigned    busy_cycles = 0;
    int unsigned    dut_pops    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clr_stats();
        xfers       = 0;
        done_cnt    = 0;
        busy_cycles = 0;
        dut_pops    = 0;
    endtask

    // Drive the datapath responder for the current cycle, update the models, then advance.
    task automatic cycle();
        evt_rec_t rec;
        evt_rec_t head;
        logic     drop;
        drop     = 1'b0;
        dp_ack   = (ack_delay == 0) ? 1'b1 : (dp_req && (wait_cnt >= ack_delay));
        dp_spike = dp_req ? spike_mask[dp_idx] : 1'b0;
        if (!rst) begin
            check("evt_valid", evt_valid, sb.size() != 0);
            check("evt_overflow", evt_overflow, exp_ovf);
            if (evt_valid && evt_ready) dut_pops++;
            if (sb.size() != 0 && evt_ready) begin
                head = sb.pop_front();
                check("evt_id", evt_id, head.id);
                check("evt_time", evt_time, head.ts);
            end
            if (busy) busy_cycles++;
            if (tick_done) done_cnt++;
            if (dp_req) check("dp_idx", dp_idx, exp_idx);
            if (dp_req && dp_ack) begin
                xfers++;
                if (dp_spike) begin
                    if (sb.size() < DEPTH) begin
                        rec.id = EVT_ID_W'(exp_idx);
                        rec.ts = EVT_TS_W'(exp_ts);
                        sb.push_back(rec);
                    end else begin
                        drop = 1'b1;
                    end
                end
                exp_idx++;
                wait_cnt = 0;
            end else if (dp_req) begin
                wait_cnt++;
            end
            if (tick_done) exp_ts++;
            if (drop) exp_ovf = 1'b1;
            else if (clear_status) exp_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int unsigned max_cyc);
        int unsigned n = 0;
        while (!(done_cnt != 0 && !busy) && n < max_cyc) begin
            cycle();
            n++;
        end
        check("sweep_done", done_cnt, 1);
    endtask

    task automatic run_sweep(input int unsigned max_cyc);
        clr_stats();
        exp_idx    = '0;
        tick_start = 1'b1;
        cycle();
        tick_start = 1'b0;
        wait_done(max_cyc);
    endtask

    task automatic check_reset(input string t);
        check({t, "_busy"}, busy, 0);
        check({t, "_tick_done"}, tick_done, 0);
        check({t, "_dp_req"}, dp_req, 0);
        check({t, "_dp_idx"}, dp_idx, 0);
        check({t, "_timestep"}, timestep, 0);
        check({t, "_evt_valid"}, evt_valid, 0);
        check({t, "_evt_overflow"}, evt_overflow, 0);
        check({t, "_tick_overrun"}, tick_overrun, 0);
        check({t, "_evt_id"}, evt_id, 0);
        check({t, "_evt_time"}, evt_time, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n;
        rst          = 1'b1;
        tick_start   = 1'b0;
        dp_ack       = 1'b0;
        dp_spike     = 1'b0;
        evt_ready    = 1'b0;
        clear_status = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset("rst");

        // Spikes on 1 and 3, ack tied high, consumer always ready.
        spike_mask = 4'b1010;
        evt_ready  = 1'b1;
        ack_delay  = 0;
        run_sweep(40);
        check("a_xfers", xfers, 4);
        check("a_busy_cycles", busy_cycles, 5);
        check("a_timestep", timestep, 1);
        repeat (2) cycle();
        check("a_pops", dut_pops, 2);

        // Slow datapath: ack after three wait cycles per neuron.
        spike_mask = '0;
        ack_delay  = 3;
        run_sweep(100);
        check("b_xfers", xfers, 4);
        check("b_busy_cycles", busy_cycles, 17);
        check("b_timestep", timestep, 2);

        // Four spikes into a two-entry FIFO with the consumer stalled.
        spike_mask = 4'b1111;
        ack_delay  = 0;
        evt_ready  = 1'b0;
`ifndef LIF_SCHED_BACKPRESSURE_EN
        run_sweep(40);
        check("ovf_xfers", xfers, 4);
        check("ovf_flag", evt_overflow, 1);
        evt_ready = 1'b1;
        dut_pops  = 0;
        repeat (4) cycle();
        check("ovf_pops", dut_pops, 2);
        check("ovf_drained", evt_valid, 0);
`else
        clr_stats();
        exp_idx    = '0;
        tick_start = 1'b1;
        cycle();
        tick_start = 1'b0;
        repeat (8) cycle();
        check("bp_stall_busy", busy, 1);
        check("bp_stall_req", dp_req, 0);
        check("bp_stall_xfers", xfers, 2);
        check("bp_stall_idx", dp_idx, 2);
        evt_ready = 1'b1;
        wait_done(40);
        repeat (3) cycle();
        check("bp_xfers", xfers, 4);
        check("bp_overflow", evt_overflow, 0);
        check("bp_pops", dut_pops, 4);
`endif

        // Overrun: tick_start mid-sweep, coincident with clear_status.
        spike_mask   = '0;
        evt_ready    = 1'b1;
        clear_status = 1'b1;
        cycle();
        clear_status = 1'b0;
        check("clr_overflow", evt_overflow, 0);
        check("clr_overrun", tick_overrun, 0);
        clr_stats();
        exp_idx    = '0;
        tick_start = 1'b1;
        cycle();
        tick_start = 1'b0;
        cycle();
        tick_start   = 1'b1;
        clear_status = 1'b1;
        cycle();
        tick_start   = 1'b0;
        clear_status = 1'b0;
        check("ovr_set_wins", tick_overrun, 1);
        wait_done(40);
        repeat (3) cycle();
        check("ovr_done_cnt", done_cnt, 1);
        check("ovr_idle", busy, 0);
        check("ovr_xfers", xfers, 4);
        clear_status = 1'b1;
        cycle();
        clear_status = 1'b0;
        check("ovr_clear", tick_overrun, 0);

        // Timestep wraps modulo 8.
        for (int i = 0; i < 5; i++) begin
            run_sweep(40);
            check("ts_step", timestep, exp_ts);
        end
        check("ts_wrap", timestep, 1);

        // Reset in the middle of a sweep at dp_idx=2.
        clr_stats();
        exp_idx    = '0;
        tick_start = 1'b1;
        cycle();
        tick_start = 1'b0;
        n = 0;
        while (!(dp_req && dp_idx == 2'd2) && n < 20) begin
            cycle();
            n++;
        end
        check("mid_reach_idx2", dp_idx, 2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sb.delete();
        exp_idx  = '0;
        exp_ts   = '0;
        exp_ovf  = 1'b0;
        wait_cnt = 0;
        check_reset("mid");
        run_sweep(40);
        check("post_rst_xfers", xfers, 4);
        check("post_rst_timestep", timestep, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
